// File: rtl/gups_engine.sv
// GUPS update engine: LFSR-addressed read-modify-write over a req/wr/rdy port.
// Increment or XOR update modes, with counters and start/stop control.
module gups_engine #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       seed,
    input  logic [ADDR_W-1:0] range,
    input  logic [CNT_W-1:0]  num_updates,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  update_cnt,
    output logic [47:0]       cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MOD,
        S_WR,
        S_NEXT
    } state_t;

    localparam logic [31:0]       POLY     = 32'h8020_0003;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [DATA_W-1:0] DATA_ONE = 1;
    localparam logic [47:0]       CYC_ONE  = 48'd1;

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] range_q, range_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  update_cnt_q, update_cnt_d;
    logic [47:0]       cycle_cnt_q, cycle_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stop_pend_q, stop_pend_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        logic [31:0] r;
        r = l >> 1;
        if (l[0]) begin
            r = r ^ POLY;
        end
        return r;
    endfunction

    // Zero-extend (or truncate) the 32-bit LFSR to the address width.
    function automatic logic [ADDR_W-1:0] lfsr_addr(input logic [31:0] l);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W && i < 32; i++) begin
            r[i] = l[i];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_rep(input logic [31:0] l);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int c = 0; c < DATA_W / 32; c++) begin
            r[c*32 +: 32] = l;
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        range_d      = range_q;
        num_d        = num_q;
        mode_d       = mode_q;
        rdata_d      = rdata_q;
        wdata_d      = wdata_q;
        update_cnt_d = update_cnt_q;
        cycle_cnt_d  = busy_q ? cycle_cnt_q + CYC_ONE : cycle_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        stop_pend_d  = busy_q & (stop_pend_q | stop);
        mem_req      = 1'b0;
        mem_wr       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    update_cnt_d = '0;
                    cycle_cnt_d  = '0;
                    if (num_updates == '0) begin
                        done_d = 1'b1;
                    end else begin
                        lfsr_d  = {~seed, seed};
                        range_d = range;
                        num_d   = num_updates;
                        mode_d  = mode;
                        busy_d  = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    rdata_d = mem_rdata;
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                wdata_d = mode_q ? (rdata_q ^ lfsr_rep(lfsr_q))
                                 : (rdata_q + DATA_ONE);
                state_d = S_WR;
            end
            S_WR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_rdy) begin
                    update_cnt_d = update_cnt_q + CNT_ONE;
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                lfsr_d = lfsr_step(lfsr_q);
                // A stop seen in this very cycle still ends the run here.
                if (update_cnt_q == num_q || stop_pend_q || stop) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            range_q      <= '0;
            num_q        <= '0;
            mode_q       <= 1'b0;
            rdata_q      <= '0;
            wdata_q      <= '0;
            update_cnt_q <= '0;
            cycle_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            range_q      <= range_d;
            num_q        <= num_d;
            mode_q       <= mode_d;
            rdata_q      <= rdata_d;
            wdata_q      <= wdata_d;
            update_cnt_q <= update_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    assign mem_addr   = lfsr_addr(lfsr_q) & range_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign update_cnt = update_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule
